// File: rtl/mu0_io_pkg.sv
// mu0_io_pkg: shared MU0 I/O defaults, keypad register address and keypad helpers.
package mu0_io_pkg;
  localparam int SCAN_DIV_DEF = 25000;
  localparam int DEBOUNCE_FRAMES_DEF = 4;
  localparam logic [11:0] KEYPAD_ADDR = 12'hFF2;
  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) lowest_idx = 4'(i);
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser with a configurable reset value.
module sync2 #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta, r_sync;
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end
  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 column-scanned keypad with frame-level debounce and key-press pulse.
module keypad_scanner
  import mu0_io_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] keypad,
  output logic        key_press,
  output logic [3:0]  key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
  logic [3:0]    w_row_s;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col;
  logic [3:0]    r_col_n;
  logic [15:0]   r_raw, r_prev, r_keypad;
  logic [3:0]    r_stable, r_key_code;
  logic          r_key_press;
  logic          w_wrap, w_frame_done, w_load;
  logic [15:0]   w_frame, w_new;
  logic [3:0]    w_stable_nxt;
  sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
    .Clk    (Clk),
    .nReset (nReset),
    .i_d    (row_n),
    .o_q    (w_row_s)
  );
  // The frame includes the sample taken this cycle, so column 3 needs no extra slot.
  always_comb begin
    w_frame = r_raw;
    for (int r = 0; r < 4; r++) w_frame[r*4 + int'(r_col)] = ~w_row_s[r];
  end
  assign w_wrap       = r_div == DIV_MAX;
  assign w_frame_done = w_wrap && r_col == 2'd3;
  assign w_stable_nxt = (w_frame != r_prev) ? 4'd1 : (r_stable == DF) ? DF : r_stable + 4'd1;
  assign w_new        = w_frame & ~r_keypad;
  assign w_load       = w_frame_done && w_stable_nxt == DF && w_frame != r_keypad;
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_div       <= '0;
      r_col       <= 2'd0;
      r_col_n     <= 4'b1110;
      r_raw       <= '0;
      r_prev      <= '0;
      r_stable    <= '0;
      r_keypad    <= '0;
      r_key_press <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_div       <= w_wrap ? '0 : r_div + DW'(1);
      r_key_press <= 1'b0;
      if (w_wrap) begin
        r_raw   <= w_frame;
        r_col   <= r_col + 2'd1;
        r_col_n <= ~(4'b0001 << (r_col + 2'd1));
      end
      if (w_frame_done) begin
        r_prev   <= w_frame;
        r_stable <= w_stable_nxt;
      end
      if (w_load) begin
        r_keypad    <= w_frame;
        r_key_press <= |w_new;
        if (|w_new) r_key_code <= lowest_idx(w_new);
      end
    end
  end
  assign col_n     = r_col_n;
  assign keypad    = r_keypad;
  assign key_press = r_key_press;
  assign key_code  = r_key_code;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, press pulse and reset behaviour.
module tb_keypad_scanner;
  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad;
  logic        key_press;
  logic [3:0]  key_code;
  logic [15:0] keys = '0;
  int passed = 0, total = 0, press_cnt = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .row_n     (row_n),
    .col_n     (col_n),
    .keypad    (keypad),
    .key_press (key_press),
    .key_code  (key_code)
  );

  always #5 Clk = ~Clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge Clk) if (key_press === 1'b1) press_cnt++;

  // Returns at the negedge just after a frame boundary (col_n 0111 -> 1110).
  task automatic next_frame();
    logic [3:0] p;
    p = col_n;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      if (p == 4'b0111 && col_n == 4'b1110) return;
      p = col_n;
    end
    total++;
    $display("FAIL frame_timeout: no frame boundary within 40 cycles, col_n=%b", col_n);
  endtask

  task automatic expect_kp(input string name, input logic [15:0] exp_kp);
    total++;
    if (keypad !== exp_kp) $display("FAIL %s keypad: got %h want %h", name, keypad, exp_kp);
    else passed++;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(negedge Clk);
    total++;
    if ({keypad, key_press, key_code, col_n} !== {16'h0, 1'b0, 4'h0, 4'b1110})
      $display("FAIL reset_values: got kp=%h kpr=%b code=%h col_n=%b want 0000 0 0 1110",
               keypad, key_press, key_code, col_n);
    else passed++;
    nReset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_idle();
    int pc0;
    next_frame();
    pc0 = press_cnt;
    for (int k = 0; k < 160; k++) begin
      total++;
      if (col_n !== ~(4'b0001 << ((k / 4) % 4)))
        $display("FAIL idle_col_n k=%0d: got %b want %b", k, col_n, ~(4'b0001 << ((k / 4) % 4)));
      else passed++;
      if (k % 16 == 15) expect_kp("idle", 16'h0);
      @(negedge Clk);
    end
    total++;
    if (press_cnt != pc0) $display("FAIL idle_press: got %0d pulses want 0", press_cnt - pc0);
    else passed++;
  endtask

  // Hold new key set from a frame start; keypad must change exactly on the 3rd boundary.
  task automatic settle(input string name, input logic [15:0] k, input logic [15:0] old_kp,
                        input logic exp_press, input logic [3:0] exp_code);
    int pc0;
    pc0 = press_cnt;
    keys = k;
    next_frame(); expect_kp({name, "_f1"}, old_kp);
    next_frame(); expect_kp({name, "_f2"}, old_kp);
    next_frame(); expect_kp({name, "_f3"}, k);
    total++;
    if (key_press !== exp_press || key_code !== exp_code)
      $display("FAIL %s pulse: got press=%b code=%0d want press=%b code=%0d",
               name, key_press, key_code, exp_press, exp_code);
    else passed++;
    @(negedge Clk);
    total++;
    if (key_press !== 1'b0) $display("FAIL %s pulse_width: got press=%b want 0", name, key_press);
    else passed++;
    next_frame();
    total++;
    if (press_cnt - pc0 != int'(exp_press))
      $display("FAIL %s pulse_count: got %0d want %0d", name, press_cnt - pc0, exp_press);
    else passed++;
    expect_kp({name, "_hold"}, k);
  endtask

  task automatic test_single_key();
    next_frame();
    settle("key6", 16'h0040, 16'h0000, 1'b1, 4'd6);
    settle("rel6", 16'h0000, 16'h0040, 1'b0, 4'd6);
  endtask

  task automatic test_multi_key();
    settle("key0_15", 16'h8001, 16'h0000, 1'b1, 4'd0);
    settle("rel0", 16'h8000, 16'h8001, 1'b0, 4'd0);
    settle("rel15", 16'h0000, 16'h8000, 1'b0, 4'd0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      next_frame();
      expect_kp("bounce", 16'h0000);
    end
    settle("bounce_stable", 16'h0040, 16'h0000, 1'b1, 4'd6);
  endtask

  task automatic test_reset_mid_frame();
    for (int n = 0; n < 20 && col_n != 4'b1011; n++) @(negedge Clk);
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    total++;
    if ({keypad, key_press, key_code, col_n} !== {16'h0, 1'b0, 4'h0, 4'b1110})
      $display("FAIL midreset_values: got kp=%h kpr=%b code=%h col_n=%b want 0000 0 0 1110",
               keypad, key_press, key_code, col_n);
    else passed++;
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    total++;
    if (col_n !== 4'b1110) $display("FAIL midreset_col0: got %b want 1110", col_n);
    else passed++;
    next_frame(); expect_kp("midreset_f1", 16'h0000);
    next_frame(); expect_kp("midreset_f2", 16'h0000);
    next_frame(); expect_kp("midreset_f3", 16'h0040);
    total++;
    if (key_press !== 1'b1 || key_code !== 4'd6)
      $display("FAIL midreset_pulse: got press=%b code=%0d want press=1 code=6", key_press, key_code);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_key();
    test_multi_key();
    test_bounce();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
